// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: command, write-data, read-data and controller request signals of the bus master
interface mem_bus_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;
  logic              busy;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic [DATA_W-1:0] mem_data;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready, mem_data,
    output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy, cpu_wr, cpu_rd, cpu_addr, cpu_data
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready, mem_data,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy, cpu_wr, cpu_rd, cpu_addr, cpu_data
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: single/burst command initiator driving a memory controller request port
module mem_bus_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  mem_bus_master_if.master bus
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_PULSE, WR_HOLD, RD_ISSUE, RD_WAIT, RD_OUT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, beats_q, beats_d, cpu_addr_q, cpu_addr_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d, rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d, wdata_ready_q, wdata_ready_d;
  logic              rdata_valid_q, rdata_valid_d, rdata_last_q, rdata_last_d;
  logic              busy_q, busy_d, cpu_wr_q, cpu_wr_d, cpu_rd_q, cpu_rd_d;

  // Burst sequencing; every output is decoded from the upcoming state so it is registered
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    cnt_d      = cnt_q;
    cpu_addr_d = cpu_addr_q;
    cpu_data_d = cpu_data_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: if (bus.cmd_valid && cmd_ready_q) begin
        addr_d  = bus.cmd_addr;
        beats_d = bus.cmd_len;
        state_d = bus.cmd_write ? WR_DATA : RD_ISSUE;
      end
      WR_DATA: if (bus.wdata_valid && wdata_ready_q) begin
        cpu_data_d = bus.wdata;
        cpu_addr_d = addr_q;
        state_d    = WR_PULSE;
      end
      WR_PULSE: state_d = WR_HOLD;
      WR_HOLD, RD_OUT: if (state_q == WR_HOLD || (bus.rdata_ready && rdata_valid_q)) begin
        beats_d = beats_q - ADDR_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        state_d = (beats_q == '0) ? IDLE : (state_q == WR_HOLD) ? WR_DATA : RD_ISSUE;
      end
      RD_ISSUE: begin
        cnt_d   = CW'(RD_LAT - 1);
        rdata_d = (RD_LAT == 0) ? bus.mem_data : rdata_q;
        state_d = (RD_LAT == 0) ? RD_OUT : RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d   = cnt_q - CW'(1);
        rdata_d = (cnt_q == '0) ? bus.mem_data : rdata_q;
        state_d = (cnt_q == '0) ? RD_OUT : RD_WAIT;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RD_ISSUE) cpu_addr_d = addr_d;
    cmd_ready_d   = state_d == IDLE;
    wdata_ready_d = state_d == WR_DATA;
    rdata_valid_d = state_d == RD_OUT;
    rdata_last_d  = state_d == RD_OUT && beats_d == '0;
    busy_d        = state_d != IDLE;
    cpu_wr_d      = state_d == WR_PULSE;
    cpu_rd_d      = state_d == RD_ISSUE;
  end

  // State and output registers; reset drops the strobes without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      beats_q       <= '0;
      cnt_q         <= '0;
      cpu_addr_q    <= '0;
      cpu_data_q    <= '0;
      rdata_q       <= '0;
      cmd_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      cpu_wr_q      <= 1'b0;
      cpu_rd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      beats_q       <= beats_d;
      cnt_q         <= cnt_d;
      cpu_addr_q    <= cpu_addr_d;
      cpu_data_q    <= cpu_data_d;
      rdata_q       <= rdata_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_last_q  <= rdata_last_d;
      busy_q        <= busy_d;
      cpu_wr_q      <= cpu_wr_d;
      cpu_rd_q      <= cpu_rd_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.wdata_ready = wdata_ready_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_last  = rdata_last_q;
  assign bus.busy        = busy_q;
  assign bus.cpu_wr      = cpu_wr_q;
  assign bus.cpu_rd      = cpu_rd_q;
  assign bus.cpu_addr    = cpu_addr_q;
  assign bus.cpu_data    = cpu_data_q;
endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator that drives the memory controller's request interface (cpu_wr/cpu_rd/cpu_addr/cpu_data) and collects read data from mem_data.
- Accepts single or burst commands over a valid/ready command channel, streams write data in and read data out with backpressure.
- Address auto-increments per beat and wraps modulo 2^ADDR_W.
- Sits between the core's load/store path or test sequencers and the memory controller.

Parameters:
ADDR_W, 4, address width; equals the controller address width.
DATA_W, 8, data width.
RD_LAT, 1, number of cycles from the cpu_rd cycle to the cycle in which mem_data is valid; 0 means valid in the same cycle.

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start address
cmd_len  in  ADDR_W  beats minus 1 (0..15)
wdata_valid  in  1  write beat offered
wdata_ready  out  1  write beat accepted when both high
wdata  in  DATA_W  write beat
rdata_valid  out  1  read beat available
rdata_ready  in  1  read beat consumed when both high
rdata  out  DATA_W  read beat
rdata_last  out  1  final beat of burst, qualified by rdata_valid
busy  out  1  burst in progress
cpu_wr  out  1  write strobe to controller
cpu_rd  out  1  read strobe to controller
cpu_addr  out  ADDR_W  address to controller
cpu_data  out  DATA_W  write data to controller
mem_data  in  DATA_W  read data from controller

Behaviour:
- rst is asynchronous, active-high; clock is clk.
- All outputs are registered.
- Reset values: cmd_ready=0, wdata_ready=0, rdata_valid=0, rdata=0, rdata_last=0, busy=0, cpu_wr=0, cpu_rd=0, cpu_addr=0, cpu_data=0.
- FSM states: IDLE, WR_DATA, WR_PULSE, WR_HOLD, RD_ISSUE, RD_WAIT, RD_OUT. Reset enters IDLE.
- IDLE: cmd_ready=1 from the first cycle after reset release; busy=0.
  - On a handshake, latch addr=cmd_addr and beats=cmd_len, set cmd_ready=0 and busy=1.
  - Next state: WR_DATA if cmd_write=1, else RD_ISSUE.
- WR_DATA: wdata_ready=1. On a wdata handshake, set cpu_data=wdata and cpu_addr=addr, then go to WR_PULSE.
- WR_PULSE: exactly one cycle with cpu_wr=1.
- WR_HOLD: one cycle with cpu_wr=0 and cpu_addr/cpu_data unchanged. The controller registers wr/data one cycle late but uses the live address, so the address must stay stable here.
  - Then, if beats==0, go to IDLE.
  - Otherwise decrement beats, set addr=addr+1 (mod 2^ADDR_W), and go to WR_DATA.
- Write throughput: 3 cycles per beat minimum.
- RD_ISSUE: one cycle with cpu_rd=1 and cpu_addr=addr.
- RD_WAIT: counter runs RD_LAT cycles with cpu_rd=0 and cpu_addr held.
  - mem_data is sampled into rdata at the edge ending cycle (issue + RD_LAT).
  - With RD_LAT=0, RD_WAIT is skipped and the sample happens at the end of RD_ISSUE.
- RD_OUT: rdata_valid=1 and rdata_last=(beats==0); rdata stays stable until the handshake.
  - On handshake with beats==0: go to IDLE.
  - On handshake with beats!=0: decrement beats, set addr+1 with wrap, go to RD_ISSUE.
  - No new read is issued while a beat is pending (single-entry output buffer).
- cmd_valid outside IDLE is ignored. Command inputs are sampled only at the handshake.
- wdata_valid outside WR_DATA is ignored; no data is consumed.
- Address wrap: 0xF+1 -> 0x0 within a burst; the burst continues normally.
- Reset mid-burst: immediately forces IDLE and the reset values (cpu_wr/cpu_rd drop asynchronously). The burst is discarded and no further beats are produced.
- Strobes: cpu_wr and cpu_rd are never high simultaneously and never high for two consecutive cycles.

Test Plan:
- Single write (RD_LAT=1): cmd addr=0x3, len=0, write, wdata=0xA5 -> one cpu_wr pulse with cpu_addr=0x3 and cpu_data=0xA5, addr held the following cycle, then IDLE; memory[3]=0xA5.
- Single read: after the above, cmd addr=0x3, read, len=0 -> cpu_rd one cycle; rdata_valid=1 with rdata=0xA5 and rdata_last=1 on cycle issue+RD_LAT+1.
- Wrapping write burst: addr=0xE, len=3, data 0x11,0x22,0x33,0x44 -> cpu_addr sequence 0xE,0xF,0x0,0x1; memory holds those values; busy drops after the 4th WR_HOLD.
- Read burst with backpressure: read addr=0xE, len=3, rdata_ready low 5 cycles per beat -> rdata stable while stalled; beats 0x11,0x22,0x33,0x44; rdata_last only on 0x44; no cpu_rd while rdata_valid=1.
- Busy/ignore: cmd_valid held high during a write burst with a different addr -> cmd_ready=0 and the command is not taken; it is accepted the cycle after IDLE is re-entered.
- Reset mid-burst: assert rst during WR_PULSE of beat 2 of 4 -> cpu_wr=0 immediately, all outputs at reset values; after release cmd_ready=1 next cycle; only beat 1 is written.
